pipe_muxn: RTL

Parametrised N-way selector with a one-cycle registered output and a valid/ready handshake. Generalises the combinational 3-way operand/result mux to any input count and data width. Includes a two-entry skid buffer so that inter-stage back-pressure never creates a combinational ready path. Used between pipeline stages, e.g. writeback result select (ALU / load / PC+4) and forwarding operand select, where the selected value must be registered and held through stalls and dropped on flush.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/muxn_comb.sv | 29 ++
 rtl/pipe_muxn.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width, select encodings and the
// occupancy states of the registered N-way selector.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } mux_state_e;

endpackage

// File: rtl/muxn_comb.sv
// Combinational N-way select; out-of-range selects yield DEFAULT_VAL and err.
module muxn_comb #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_IN      = 3,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int                   SEL_WIDTH   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        data,
  output logic                         err
);

  // One extra bit so a select beyond NUM_IN can never match a real input.
  logic [SEL_WIDTH:0] sel_ext;
  assign sel_ext = {1'b0, sel};

  always_comb begin
    data = DEFAULT_VAL;
    err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == k[SEL_WIDTH:0]) begin
        data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_muxn.sv
// Registered N-way selector with valid/ready handshake and a two-entry
// skid buffer so that out_ready never reaches in_ready combinationally.
module pipe_muxn
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH  = XLEN,
  parameter int                    NUM_IN      = 3,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int                   SEL_WIDTH   = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sel_err,
  output logic                         out_valid,
  input  logic                         out_ready
);

  mux_state_e state, state_nxt;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] main_data, skid_data;
  logic                  main_err, skid_err;
  logic                  in_ready_q;
  logic                  accept, out_xfer;
  logic                  load_main_new, load_main_skid, load_skid;

  muxn_comb #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_IN     (NUM_IN),
    .DEFAULT_VAL(DEFAULT_VAL)
  ) u_sel (
    .in_data(in_data),
    .sel    (in_sel),
    .data   (sel_data),
    .err    (sel_err)
  );

  assign accept      = in_valid && in_ready_q;
  assign out_xfer    = out_valid && out_ready;
  assign out_valid   = (state != ST_EMPTY);
  assign in_ready    = in_ready_q;
  assign out_data    = main_data;
  assign out_sel_err = main_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  // Flush wins over everything and leaves the data registers untouched.
  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt     = ST_ONE;
            load_main_new = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && out_xfer) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_data <= sel_data;
        main_err  <= sel_err;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

endmodule
